// File: rtl/simmem_row_sched.sv
// rtl/simmem_row_sched.sv - single-bank open-page row-buffer scheduler
module simmem_row_sched #(
    parameter int AddrW          = 16,
    parameter int RowBufLenW     = 8,
    parameter int IidW           = 5,
    parameter int RowHitCost     = 4,
    parameter int PrechargeCost  = 2,
    parameter int ActivationCost = 1,
    parameter int CntW           = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             w_valid_i,
    output logic             w_ready_o,
    input  logic [AddrW-1:0] w_addr_i,
    input  logic [IidW-1:0]  w_iid_i,
    input  logic             r_valid_i,
    output logic             r_ready_o,
    input  logic [AddrW-1:0] r_addr_i,
    input  logic [IidW-1:0]  r_iid_i,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic [IidW-1:0]  done_iid_o,
    output logic             done_is_wr_o,
    output logic             busy_o
);

    localparam int RowW = AddrW - RowBufLenW;

    localparam logic [CntW-1:0] HIT_D    = CntW'(RowHitCost);
    localparam logic [CntW-1:0] CLOSED_D = CntW'(ActivationCost + RowHitCost);
    localparam logic [CntW-1:0] MISS_D   = CntW'(PrechargeCost + ActivationCost + RowHitCost);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              row_open_q;
    logic [RowW-1:0]   open_row_q;
    logic [CntW-1:0]   cnt_q;
    logic              rr_q;          // 0 = write preferred, 1 = read preferred
    logic [IidW-1:0]   iid_q;
    logic              is_wr_q;

    logic [RowW-1:0]   w_row;
    logic [RowW-1:0]   r_row;
    logic              w_hit;
    logic              r_hit;
    logic              grant_w;
    logic              grant_r;
    logic              rr_decided;
    logic [RowW-1:0]   grant_row;
    logic [CntW-1:0]   grant_delay;

    // Column bits do not affect scheduling; only the row id matters.
    logic              unused_col_bits;
    assign unused_col_bits = ^{w_addr_i[RowBufLenW-1:0], r_addr_i[RowBufLenW-1:0]};

    assign w_row = w_addr_i[AddrW-1:RowBufLenW];
    assign r_row = r_addr_i[AddrW-1:RowBufLenW];
    assign w_hit = row_open_q && (w_row == open_row_q);
    assign r_hit = row_open_q && (r_row == open_row_q);

    // Arbitration: row hits win over misses, ties fall back to round robin.
    always_comb begin
        grant_w    = 1'b0;
        grant_r    = 1'b0;
        rr_decided = 1'b0;
        if (state_q == IDLE) begin
            if (w_valid_i && r_valid_i) begin
                if (w_hit != r_hit) begin
                    grant_w = w_hit;
                    grant_r = r_hit;
                end else begin
                    rr_decided = 1'b1;
                    grant_w    = ~rr_q;
                    grant_r    = rr_q;
                end
            end else begin
                grant_w = w_valid_i;
                grant_r = r_valid_i;
            end
        end
    end

    // Access cost of the granted request given the current row-buffer state.
    always_comb begin
        grant_row = grant_w ? w_row : r_row;
        if (!row_open_q) begin
            grant_delay = CLOSED_D;
        end else if (grant_row == open_row_q) begin
            grant_delay = HIT_D;
        end else begin
            grant_delay = MISS_D;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: grant starts the countdown, the consumer releases DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_w || grant_r) state_d = BUSY;
            BUSY: if (cnt_q == '0)        state_d = DONE;
            DONE: if (done_ready_i)       state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Row-buffer tracking, request latching and the delay countdown.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_open_q <= 1'b0;
            open_row_q <= '0;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            iid_q      <= '0;
            is_wr_q    <= 1'b0;
        end else if (grant_w || grant_r) begin
            iid_q      <= grant_w ? w_iid_i : r_iid_i;
            is_wr_q    <= grant_w;
            open_row_q <= grant_row;
            row_open_q <= 1'b1;
            cnt_q      <= grant_delay - CntW'(1);
            if (rr_decided) begin
                rr_q <= ~rr_q;
            end
        end else if ((state_q == BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign w_ready_o    = grant_w;
    assign r_ready_o    = grant_r;
    assign done_valid_o = (state_q == DONE);
    assign done_iid_o   = iid_q;
    assign done_is_wr_o = is_wr_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_simmem_row_sched.sv
// tb/tb_simmem_row_sched.sv - randomized model-checked bench for simmem_row_sched
module tb_simmem_row_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_valid, r_valid, done_ready;
    logic [15:0] w_addr, r_addr;
    logic [4:0]  w_iid, r_iid;
    logic        w_ready, r_ready, done_valid, done_is_wr, busy;
    logic [4:0]  done_iid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    simmem_row_sched dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .w_valid_i    (w_valid),
        .w_ready_o    (w_ready),
        .w_addr_i     (w_addr),
        .w_iid_i      (w_iid),
        .r_valid_i    (r_valid),
        .r_ready_o    (r_ready),
        .r_addr_i     (r_addr),
        .r_iid_i      (r_iid),
        .done_valid_o (done_valid),
        .done_ready_i (done_ready),
        .done_iid_o   (done_iid),
        .done_is_wr_o (done_is_wr),
        .busy_o       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one request in flight, completion at grant cycle + cost.
    bit         chk_en = 1'b0;
    bit         m_inflight = 1'b0;
    int         m_cyc = 0;
    int         m_gcyc = 0;
    int         m_gd = 0;
    logic [4:0] m_iid = '0;
    bit         m_is_wr = 1'b0;
    bit         m_row_open = 1'b0;
    logic [7:0] m_open_row = '0;
    bit         m_rr = 1'b0;

    function automatic bit m_done();
        return m_inflight && ((m_cyc - m_gcyc) >= m_gd);
    endfunction

    function automatic void m_arb(output bit gw, output bit gr, output bit by_rr);
        bit wh, rh;
        gw = 1'b0; gr = 1'b0; by_rr = 1'b0;
        if (m_inflight) return;
        wh = m_row_open && (w_addr[15:8] == m_open_row);
        rh = m_row_open && (r_addr[15:8] == m_open_row);
        if (w_valid && r_valid) begin
            if (wh != rh) begin
                gw = wh; gr = rh;
            end else begin
                by_rr = 1'b1; gw = !m_rr; gr = m_rr;
            end
        end else begin
            gw = w_valid; gr = r_valid;
        end
    endfunction

    function automatic int m_cost(input logic [7:0] row);
        if (!m_row_open) return 1 + 4;
        if (row == m_open_row) return 4;
        return 2 + 1 + 4;
    endfunction

    // Advance the model on each clock edge from the inputs present at that edge.
    always @(posedge clk) begin
        bit gw, gr, br, dv;
        logic [7:0] row;
        dv = m_done();
        m_arb(gw, gr, br);
        m_cyc++;
        if (rst) begin
            m_inflight = 1'b0; m_row_open = 1'b0; m_open_row = '0; m_rr = 1'b0;
        end else if (m_inflight) begin
            if (dv && done_ready) m_inflight = 1'b0;
        end else if (gw || gr) begin
            row        = gw ? w_addr[15:8] : r_addr[15:8];
            m_gd       = m_cost(row);
            m_gcyc     = m_cyc;
            m_inflight = 1'b1;
            m_iid      = gw ? w_iid : r_iid;
            m_is_wr    = gw;
            m_open_row = row;
            m_row_open = 1'b1;
            if (br) m_rr = !m_rr;
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk) begin
        bit gw, gr, br, dv;
        if (chk_en) begin
            dv = m_done();
            m_arb(gw, gr, br);
            check("w_ready", w_ready, gw);
            check("r_ready", r_ready, gr);
            check("done_valid", done_valid, dv);
            check("busy", busy, m_inflight);
            if (dv) begin
                check("done_iid", done_iid, m_iid);
                check("done_is_wr", done_is_wr, m_is_wr);
            end
        end
    end

    // Present one request (or pair), wait for the grant and completion, then consume.
    task automatic issue(input bit wv, input logic [15:0] wa, input logic [4:0] wi,
                         input bit rv, input logic [15:0] ra, input logic [4:0] ri,
                         input int hold, output bit got_w, output int lat,
                         output logic [4:0] diid, output bit dwr);
        bit granted = 1'b0;
        int k;
        got_w = 1'b0; lat = -1; diid = '0; dwr = 1'b0;
        w_valid = wv; w_addr = wa; w_iid = wi;
        r_valid = rv; r_addr = ra; r_iid = ri;
        for (int i = 0; i < 20 && !granted; i++) begin
            @(negedge clk);
            if (w_ready || r_ready) begin
                granted = 1'b1;
                got_w   = w_ready;
            end
            @(posedge clk); #2;
        end
        w_valid = 1'b0; r_valid = 1'b0;
        if (!granted) begin
            check("grant_timeout", 0, 1);
            return;
        end
        k = 0;
        @(negedge clk);
        while (!done_valid && k < 40) begin
            k++;
            @(negedge clk);
        end
        lat = k; diid = done_iid; dwr = done_is_wr;
        repeat (hold) @(negedge clk);
        @(posedge clk); #2 done_ready = 1'b1;
        @(posedge clk); #2 done_ready = 1'b0;
    endtask

    initial begin
        bit         gw;
        int         lat;
        logic [4:0] di;
        bit         dw;

        rst = 1'b1; w_valid = 1'b0; r_valid = 1'b0; done_ready = 1'b0;
        w_addr = '0; r_addr = '0; w_iid = '0; r_iid = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done_valid", done_valid, 0);
        check("reset_done_iid", done_iid, 0);
        check("reset_done_is_wr", done_is_wr, 0);
        @(posedge clk); #2;

        issue(1, 16'h0100, 5'd3, 0, 16'h0000, 5'd0, 0, gw, lat, di, dw);
        check("t1_lat", lat, 5); check("t1_dir", gw, 1);
        check("t1_iid", di, 3);  check("t1_is_wr", dw, 1);

        issue(0, 16'h0000, 5'd0, 1, 16'h01FF, 5'd4, 0, gw, lat, di, dw);
        check("t2_hit_lat", lat, 4); check("t2_is_wr", dw, 0); check("t2_iid", di, 4);

        issue(0, 16'h0000, 5'd0, 1, 16'h0200, 5'd5, 0, gw, lat, di, dw);
        check("t3_miss_lat", lat, 7);

        issue(1, 16'h0250, 5'd6, 0, 16'h0000, 5'd0, 0, gw, lat, di, dw);
        check("t4_row02_hit_lat", lat, 4);

        issue(1, 16'h0300, 5'd7, 1, 16'h0400, 5'd8, 0, gw, lat, di, dw);
        check("t5_rr_first_w", gw, 1); check("t5_lat", lat, 7);

        issue(1, 16'h0200, 5'd9, 0, 16'h0000, 5'd0, 0, gw, lat, di, dw);
        check("t6_lat", lat, 7);

        issue(1, 16'h0200, 5'd10, 1, 16'h0300, 5'd11, 0, gw, lat, di, dw);
        check("t7_hit_wins_w", gw, 1); check("t7_lat", lat, 4); check("t7_iid", di, 10);

        for (int k = 0; k < 5; k++) begin
            issue(1, {8'(8'h10 + k), 8'h00}, 5'(12 + k), 1, {8'(8'h20 + k), 8'h00}, 5'(20 + k),
                  0, gw, lat, di, dw);
            check($sformatf("t8_alt_dir_%0d", k), gw, (k % 2 == 1) ? 1 : 0);
            check($sformatf("t8_alt_lat_%0d", k), lat, 7);
        end

        issue(0, 16'h0000, 5'd0, 1, 16'h2480, 5'd17, 10, gw, lat, di, dw);
        check("t9_hold_lat", lat, 4); check("t9_hold_iid", di, 17);

        w_valid = 1'b1; w_addr = 16'h0700; w_iid = 5'd9;
        @(posedge clk); #2 w_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t10_no_done_after_rst", done_valid, 0);
        end
        @(posedge clk); #2;
        issue(1, 16'h0100, 5'd1, 0, 16'h0000, 5'd0, 0, gw, lat, di, dw);
        check("t10_closed_lat", lat, 5);

        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 255) == 0);
            w_valid    = $urandom_range(0, 1);
            r_valid    = $urandom_range(0, 1);
            w_addr     = {6'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
            r_addr     = {6'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
            w_iid      = 5'($urandom);
            r_iid      = 5'($urandom);
            done_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #2;
        end
        rst = 1'b0; w_valid = 1'b0; r_valid = 1'b0; done_ready = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
